// File: rtl/mult_div_if.sv
// Operand/result bundle between the EX-stage issue logic and the
// multiply/divide unit.
interface mult_div_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] srca;
  logic [WIDTH-1:0] srcb;
  logic             mthi;
  logic             mtlo;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;

  modport master (
    output start, op, srca, srcb, mthi, mtlo, wdata,
    input  hi, lo, busy, done
  );

  modport slave (
    input  start, op, srca, srcb, mthi, mtlo, wdata,
    output hi, lo, busy, done
  );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit holding the architectural HI/LO registers.
// Multiply: radix-2 shift-add into a 2*WIDTH accumulator.
// Divide: restoring division, remainder in the upper half of the accumulator,
// dividend/quotient shifting through the lower half.
// Signed ops run on magnitudes; the sign is fixed up in the FIX state.
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic     clk,
  input  logic     reset,
  mult_div_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  localparam logic [1:0]         OP_MULTU = 2'b00;
  localparam logic [1:0]         OP_MULT  = 2'b01;
  localparam logic [1:0]         OP_DIV   = 2'b11;
  localparam logic [WIDTH-1:0]   ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0] ONE_D    = {{(2*WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]   ONE_C    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]   CNT_LOAD = CNT_W'(WIDTH-1);

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
    return ~x + ONE_W;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_d(input logic [2*WIDTH-1:0] x);
    return ~x + ONE_D;
  endfunction

  state_t             state_r, state_s;
  logic [CNT_W-1:0]   cnt_r;
  logic [1:0]         op_r;
  logic               sign_q_r;
  logic               sign_r_r;
  logic               div_zero_r;
  logic [WIDTH-1:0]   a_raw_r;
  logic [WIDTH-1:0]   b_r;
  logic [2*WIDTH-1:0] acc_r;
  logic [WIDTH-1:0]   hi_r, lo_r;
  logic               busy_r, done_r;

  logic               start_ok_s;
  logic               a_neg_s, b_neg_s;
  logic [WIDTH-1:0]   a_mag_s, b_mag_s;
  logic [WIDTH:0]     mul_sum_s;
  logic [2*WIDTH-1:0] mul_next_s;
  logic [WIDTH:0]     div_shift_s;
  logic [WIDTH:0]     div_diff_s;
  logic [2*WIDTH-1:0] div_next_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   quo_s, rem_s;
  logic [WIDTH-1:0]   fix_hi_s, fix_lo_s;

  // Operand magnitudes and sign capture for the start cycle.
  always_comb begin
    start_ok_s = (state_r == IDLE) && bus.start;
    a_neg_s    = bus.op[0] & bus.srca[WIDTH-1];
    b_neg_s    = bus.op[0] & bus.srcb[WIDTH-1];
    if (a_neg_s) begin
      a_mag_s = neg_w(bus.srca);
    end else begin
      a_mag_s = bus.srca;
    end
    if (b_neg_s) begin
      b_mag_s = neg_w(bus.srcb);
    end else begin
      b_mag_s = bus.srcb;
    end
  end

  // One multiply step and one restoring-divide step on the accumulator.
  always_comb begin
    if (acc_r[0]) begin
      mul_sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + {1'b0, b_r};
    end else begin
      mul_sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]};
    end
    mul_next_s  = {mul_sum_s, acc_r[WIDTH-1:1]};
    div_shift_s = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]};
    div_diff_s  = div_shift_s - {1'b0, b_r};
    if (div_diff_s[WIDTH]) begin
      div_next_s = {div_shift_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
    end else begin
      div_next_s = {div_diff_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
    end
  end

  // Sign correction and divide-by-zero substitution for the final write.
  always_comb begin
    prod_s = acc_r;
    quo_s  = acc_r[WIDTH-1:0];
    rem_s  = acc_r[2*WIDTH-1:WIDTH];
    if ((op_r == OP_MULT) && sign_q_r) begin
      prod_s = neg_d(acc_r);
    end else begin
      prod_s = acc_r;
    end
    if ((op_r == OP_DIV) && sign_q_r) begin
      quo_s = neg_w(acc_r[WIDTH-1:0]);
    end else begin
      quo_s = acc_r[WIDTH-1:0];
    end
    if ((op_r == OP_DIV) && sign_r_r) begin
      rem_s = neg_w(acc_r[2*WIDTH-1:WIDTH]);
    end else begin
      rem_s = acc_r[2*WIDTH-1:WIDTH];
    end
    case (op_r)
      OP_MULTU, OP_MULT: begin
        fix_hi_s = prod_s[2*WIDTH-1:WIDTH];
        fix_lo_s = prod_s[WIDTH-1:0];
      end
      default: begin
        if (div_zero_r) begin
          fix_hi_s = a_raw_r;
          fix_lo_s = {WIDTH{1'b1}};
        end else begin
          fix_hi_s = rem_s;
          fix_lo_s = quo_s;
        end
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          state_s = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (cnt_r == {CNT_W{1'b0}}) begin
          state_s = FIX;
        end else begin
          state_s = RUN;
        end
      end
      FIX:     state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Datapath: operand capture, iteration, HI/LO writes and status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r      <= {CNT_W{1'b0}};
      op_r       <= 2'b00;
      sign_q_r   <= 1'b0;
      sign_r_r   <= 1'b0;
      div_zero_r <= 1'b0;
      a_raw_r    <= {WIDTH{1'b0}};
      b_r        <= {WIDTH{1'b0}};
      acc_r      <= {(2*WIDTH){1'b0}};
      hi_r       <= {WIDTH{1'b0}};
      lo_r       <= {WIDTH{1'b0}};
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      busy_r <= (state_s != IDLE);
      done_r <= (state_r == FIX);
      case (state_r)
        IDLE: begin
          if (start_ok_s) begin
            op_r       <= bus.op;
            sign_q_r   <= a_neg_s ^ b_neg_s;
            sign_r_r   <= a_neg_s;
            div_zero_r <= bus.op[1] & (bus.srcb == {WIDTH{1'b0}});
            a_raw_r    <= bus.srca;
            cnt_r      <= CNT_LOAD;
            // Divide shifts the dividend; multiply shifts the multiplier.
            if (bus.op[1]) begin
              acc_r <= {{WIDTH{1'b0}}, a_mag_s};
              b_r   <= b_mag_s;
            end else begin
              acc_r <= {{WIDTH{1'b0}}, b_mag_s};
              b_r   <= a_mag_s;
            end
          end else begin
            if (bus.mthi) begin
              hi_r <= bus.wdata;
            end
            if (bus.mtlo) begin
              lo_r <= bus.wdata;
            end
          end
        end
        RUN: begin
          if (op_r[1]) begin
            acc_r <= div_next_s;
          end else begin
            acc_r <= mul_next_s;
          end
          if (cnt_r != {CNT_W{1'b0}}) begin
            cnt_r <= cnt_r - ONE_C;
          end
        end
        FIX: begin
          hi_r <= fix_hi_s;
          lo_r <= fix_lo_s;
        end
        default: begin
          cnt_r <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

  assign bus.hi   = hi_r;
  assign bus.lo   = lo_r;
  assign bus.busy = busy_r;
  assign bus.done = done_r;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit with an arithmetic reference model.
module tb_mult_div_unit;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;
  logic chk_en = 1'b0;

  mult_div_if #(.WIDTH(32)) bus ();

  mult_div_unit #(.WIDTH(32), .CNT_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Result of an operation computed directly from arithmetic: {hi, lo}.
  function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint p;
    int     sa, sb, q, r;
    case (o)
      2'b00: return {32'h0, a} * {32'h0, b};
      2'b01: begin
        p = longint'($signed(a)) * longint'($signed(b));
        return p;
      end
      2'b10: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      default: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        sa = a;
        sb = b;
        q  = sa / sb;
        r  = sa % sb;
        return {r, q};
      end
    endcase
  endfunction

  // Reference model: 33-cycle occupancy, then the result lands with a done pulse.
  int          m_cnt;
  logic        m_busy, m_done;
  logic [31:0] m_hi, m_lo;
  logic [63:0] m_pend;

  always @(posedge clk) begin
    if (reset) begin
      m_cnt  <= 0;
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_hi   <= 32'h0;
      m_lo   <= 32'h0;
    end else if (m_cnt == 0) begin
      m_done <= 1'b0;
      if (bus.start) begin
        m_cnt  <= 33;
        m_busy <= 1'b1;
        m_pend <= ref_result(bus.op, bus.srca, bus.srcb);
      end else begin
        if (bus.mthi) m_hi <= bus.wdata;
        if (bus.mtlo) m_lo <= bus.wdata;
      end
    end else if (m_cnt == 1) begin
      m_cnt  <= 0;
      m_busy <= 1'b0;
      m_done <= 1'b1;
      m_hi   <= m_pend[63:32];
      m_lo   <= m_pend[31:0];
    end else begin
      m_cnt <= m_cnt - 1;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc busy", {63'h0, bus.busy}, {63'h0, m_busy});
      chk("cyc done", {63'h0, bus.done}, {63'h0, m_done});
      chk("cyc hi",   {32'h0, bus.hi},   {32'h0, m_hi});
      chk("cyc lo",   {32'h0, bus.lo},   {32'h0, m_lo});
    end
  end

  // Wait (bounded) for busy to drop, returning the number of busy cycles seen.
  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (bus.busy && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  // Issue one op, scramble operands afterwards, check latency and result literals.
  task automatic run_op(input string nm, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exph, input logic [31:0] expl, input logic now, input logic mh);
    int cyc;
    if (!now) @(negedge clk);
    bus.start = 1'b1;
    bus.op    = o;
    bus.srca  = a;
    bus.srcb  = b;
    bus.mthi  = mh;
    bus.wdata = 32'h0000_DEAD;
    @(negedge clk);
    bus.start = 1'b0;
    bus.mthi  = 1'b0;
    bus.srca  = ~a;
    bus.srcb  = ~b;
    wait_idle(cyc);
    chk({nm, " latency"}, 64'(cyc), 64'd33);
    chk({nm, " done"}, {63'h0, bus.done}, 64'h1);
    chk({nm, " hi"}, {32'h0, bus.hi}, {32'h0, exph});
    chk({nm, " lo"}, {32'h0, bus.lo}, {32'h0, expl});
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cyc;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.srca  = 32'h0;
    bus.srcb  = 32'h0;
    bus.mthi  = 1'b0;
    bus.mtlo  = 1'b0;
    bus.wdata = 32'h0;
    repeat (2) @(negedge clk);
    reset  = 1'b0;
    chk_en = 1'b1;
    chk("reset busy", {63'h0, bus.busy}, 64'h0);
    chk("reset done", {63'h0, bus.done}, 64'h0);
    chk("reset hilo", {bus.hi, bus.lo}, 64'h0);

    run_op("multu max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b0);
    run_op("mult -3x7", 2'b01, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 1'b0);
    run_op("mult -3x-3", 2'b01, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'h0000_0000, 32'h0000_0009, 1'b1, 1'b0);
    run_op("divu 100/7", 2'b10, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1'b0);
    run_op("div -7/2", 2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b1, 1'b0);
    run_op("div ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 1'b0);
    run_op("divu /0", 2'b10, 32'h0000_1234, 32'h0, 32'h0000_1234, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op("div -7/0", 2'b11, 32'hFFFF_FFF9, 32'h0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op("div 7/-2", 2'b11, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, 1'b0);

    // MULTU 3x4 with a second start and an mthi while busy; both must be ignored.
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b00; bus.srca = 32'd3; bus.srcb = 32'd4;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (8) @(negedge clk);
    bus.start = 1'b1; bus.srca = 32'd5; bus.srcb = 32'd5;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.mthi = 1'b1; bus.wdata = 32'h0000_00AA;
    @(negedge clk);
    bus.mthi = 1'b0;
    wait_idle(cyc);
    chk("busy-ignore done", {63'h0, bus.done}, 64'h1);
    chk("busy-ignore hilo", {bus.hi, bus.lo}, {32'h0, 32'd12});

    // MTLO while idle, then MTHI+MTLO together.
    @(negedge clk);
    bus.mtlo = 1'b1; bus.wdata = 32'h0000_0055;
    @(negedge clk);
    bus.mtlo = 1'b0;
    chk("mtlo hilo", {bus.hi, bus.lo}, {32'h0, 32'h0000_0055});
    bus.mthi = 1'b1; bus.mtlo = 1'b1; bus.wdata = 32'h0000_0077;
    @(negedge clk);
    bus.mthi = 1'b0; bus.mtlo = 1'b0;
    chk("mthilo hilo", {bus.hi, bus.lo}, {32'h0000_0077, 32'h0000_0077});

    // Reset in the middle of DIVU 100/7 aborts it with no partial result.
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b10; bus.srca = 32'd100; bus.srcb = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (14) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midreset busy", {63'h0, bus.busy}, 64'h0);
    chk("midreset done", {63'h0, bus.done}, 64'h0);
    chk("midreset hilo", {bus.hi, bus.lo}, 64'h0);

    // Start with a simultaneous mthi: start wins, write dropped.
    run_op("multu 2x3", 2'b00, 32'd2, 32'd3, 32'h0, 32'd6, 1'b0, 1'b1);
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative multiply/divide unit in the EX stage, directly downstream of the register file.
- Consumes the two read-port operands (rs, rt) and executes MULT/MULTU/DIV/DIVU over multiple cycles.
- Holds the architectural HI/LO registers, read by MFHI/MFLO and written by MTHI/MTLO.
- Exposes busy/done so the hazard logic can stall MFHI/MFLO and new mult/div ops.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- CNT_W, 5, iteration counter width; must satisfy 2^CNT_W = WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request to begin the operation selected by op; sampled only when busy=0.
- op  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- srca  input  WIDTH  rs operand (multiplicand / dividend).
- srcb  input  WIDTH  rt operand (multiplier / divisor).
- mthi  input  1  write wdata into HI.
- mtlo  input  1  write wdata into LO.
- wdata  input  WIDTH  data for MTHI/MTLO.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse; HI/LO hold a new result.

Behaviour:
- One clock domain: clk. Reset is synchronous, active-high, named reset.
- Reset values: hi=0, lo=0, busy=0, done=0, state=IDLE, counter=0.
- Reset has priority at any time, including mid-operation: the operation is aborted and no partial result reaches hi/lo.
- States:
  - IDLE: busy=0. On start=1, latch op and operand magnitudes (for signed ops take |x|; record sign_q = sa^sb and sign_r = sa), load counter = WIDTH-1, go to RUN.
  - RUN: busy=1.
    - Multiply: one radix-2 shift-add step per cycle into a 2*WIDTH accumulator.
    - Divide: one restoring-division step per cycle (shift remainder left, trial subtract divisor, set quotient bit if non-negative).
    - When counter=0, go to FIX; otherwise decrement the counter.
  - FIX: busy=1. Apply sign correction and write hi/lo at this edge, then go to IDLE with done=1 for exactly the next cycle.
- Latency: start sampled at edge E0 -> busy=1 from E0 through E0+WIDTH+1 -> hi/lo updated and done=1 after edge E0+WIDTH+1, i.e. 33 cycles of busy for WIDTH=32.
- A new start may be accepted in the same cycle done=1, since busy=0 then.
- Multiply result: {hi,lo} = 64-bit product. MULT negates the product if sign_q=1.
- Divide result: lo=quotient, hi=remainder.
  - DIV: quotient negated if sign_q=1; remainder negated if sign_r=1, so the remainder takes the dividend's sign.
  - DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0 (wraps, no trap).
- Divide by zero (srcb=0, DIV or DIVU): still takes the full latency; result lo=0xFFFFFFFF, hi=dividend (raw srca for DIV).
- start while busy=1: ignored, no effect on the running operation.
- mthi/mtlo: applied at the clock edge only when busy=0 and start=0.
  - Ignored while busy.
  - If start=1 in the same cycle, start wins and the write is dropped.
  - mthi and mtlo together write both registers.
- hi/lo hold their values during RUN; intermediate state lives in internal registers only.
- Operands are sampled only at the start edge; later changes on srca/srcb have no effect.

Test Plan:
- Reset, then MULTU srca=0xFFFFFFFF, srcb=0xFFFFFFFF -> busy for 33 cycles, then done pulse; hi=0xFFFFFFFE, lo=0x00000001.
- MULT srca=0xFFFFFFFD (-3), srcb=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB (-21); MULT -3 x -3 -> hi=0, lo=9.
- DIVU 100/7 -> lo=14, hi=2. DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU 0x1234/0 -> after full latency, lo=0xFFFFFFFF, hi=0x1234.
- Start MULTU 3x4, pulse start again with 5x5 at cycle 10 and assert mthi with wdata=0xAA at cycle 12 -> both ignored; result hi=0, lo=12. Then mtlo with wdata=0x55 while idle -> lo=0x55 next cycle, hi unchanged.
- Assert reset at cycle 15 of DIVU 100/7 -> next cycle busy=0, done=0, hi=lo=0. A new MULTU 2x3 then gives lo=6.
